// File: rtl/video_pkg.sv
// Shared definitions for the video test-pattern source: pattern codes,
// FSM state encoding and beat geometry.
package video_pkg;

    localparam int PIX_W = 24;
    localparam int PPC   = 4;

    localparam logic [1:0] PAT_GRAD  = 2'd0;
    localparam logic [1:0] PAT_CHECK = 2'd1;
    localparam logic [1:0] PAT_CNT   = 2'd2;
    localparam logic [1:0] PAT_FLAT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

endpackage

// File: rtl/video_pattern_px.sv
// Combinational generator for one 24-bit RGB pixel of the selected test pattern.
module video_pattern_px
    import video_pkg::*;
#(
    parameter int XW = 6,
    parameter int YW = 6
) (
    input  logic [XW-1:0]    i_px,
    input  logic [YW-1:0]    i_y,
    input  logic [7:0]       i_f,
    input  logic [23:0]      i_cnt,
    input  logic [1:0]       i_pat,
    output logic [PIX_W-1:0] o_pix
);

    logic [7:0] w_px8;
    logic [7:0] w_y8;

    // Coordinates are narrower than a colour channel for small frames.
    if (XW >= 8) begin : g_px_wide
        assign w_px8 = i_px[7:0];
    end else begin : g_px_narrow
        assign w_px8 = {{(8-XW){1'b0}}, i_px};
    end

    if (YW >= 8) begin : g_y_wide
        assign w_y8 = i_y[7:0];
    end else begin : g_y_narrow
        assign w_y8 = {{(8-YW){1'b0}}, i_y};
    end

    always_comb begin
        o_pix = '0;
        case (i_pat)
            PAT_GRAD:  o_pix = {w_px8, w_y8, i_f};
            PAT_CHECK: o_pix = (w_px8[3] ^ w_y8[3]) ? 24'hFFFFFF : 24'h000000;
            PAT_CNT:   o_pix = i_cnt;
            PAT_FLAT:  o_pix = {i_f, ~i_f, i_f};
            default:   o_pix = '0;
        endcase
    end

endmodule

// File: rtl/video_src_uhd_4.sv
// AXI4-Stream video source: four RGB pixels per beat, tuser at frame start,
// tlast at end of line, programmable idle gap between frames.
module video_src_uhd_4
    import video_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 64,
    parameter int GAP    = 16
) (
    input  logic        m_axis_video_aclk,
    input  logic        m_axis_video_arst,
    input  logic        enable,
    input  logic [1:0]  pattern,
    output logic [95:0] VIDEO_OUT_tdata,
    output logic        VIDEO_OUT_tvalid,
    input  logic        VIDEO_OUT_tready,
    output logic        VIDEO_OUT_tuser,
    output logic        VIDEO_OUT_tlast,
    output logic [7:0]  frame_cnt,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    // Handshake: a beat transfers on a rising edge where tvalid & tready.
    // tvalid is held until that edge; tdata/tuser/tlast are stable meanwhile.

    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int GW = $clog2(GAP + 1);

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - PPC);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
    localparam logic [GW-1:0] G_LAST = GW'(GAP - 1);

    state_t r_state;
    state_t w_next;

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [23:0]   r_cnt;
    logic [GW-1:0] r_gap;
    logic [7:0]    r_f;
    logic [1:0]    r_pat;
    logic [95:0]   r_tdata;
    logic          r_tuser;
    logic          r_tlast;
    logic [7:0]    r_frame_cnt;

    logic          w_load;
    logic          w_hs;
    logic          w_last_x;
    logic          w_last_y;
    logic          w_frame_end;
    logic          w_gap_done;
    logic [XW-1:0] w_nx;
    logic [YW-1:0] w_ny;
    logic [23:0]   w_ncnt;
    logic [7:0]    w_nf;
    logic [1:0]    w_npat;
    logic [95:0]   w_beat;

    assign w_hs        = (r_state == ST_ACTIVE) && VIDEO_OUT_tready;
    assign w_last_x    = (r_x == X_LAST);
    assign w_last_y    = (r_y == Y_LAST);
    assign w_frame_end = w_hs && w_last_x && w_last_y;
    assign w_gap_done  = (r_gap == G_LAST);

    always_ff @(posedge m_axis_video_aclk or posedge m_axis_video_arst) begin
        if (m_axis_video_arst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_next = ST_ACTIVE;
                    w_load = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_frame_end) begin
                    w_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_gap_done) begin
                    if (enable) begin
                        w_next = ST_ACTIVE;
                        w_load = 1'b1;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Coordinates of the beat that will occupy the output register next:
    // frame origin on a frame start, otherwise the successor of the current beat.
    always_comb begin
        w_nx   = r_x + XW'(PPC);
        w_ny   = r_y;
        w_ncnt = r_cnt + 24'(PPC);
        w_nf   = r_f;
        w_npat = r_pat;
        if (w_last_x) begin
            w_nx = '0;
            w_ny = r_y + YW'(1);
        end
        if (w_load) begin
            w_nx   = '0;
            w_ny   = '0;
            w_ncnt = '0;
            w_nf   = r_frame_cnt;
            w_npat = pattern;
        end
    end

    for (genvar k = 0; k < PPC; k++) begin : g_px
        video_pattern_px #(
            .XW (XW),
            .YW (YW)
        ) u_px (
            .i_px  (w_nx + XW'(k)),
            .i_y   (w_ny),
            .i_f   (w_nf),
            .i_cnt (w_ncnt + 24'(k)),
            .i_pat (w_npat),
            .o_pix (w_beat[k*PIX_W +: PIX_W])
        );
    end

    always_ff @(posedge m_axis_video_aclk or posedge m_axis_video_arst) begin
        if (m_axis_video_arst) begin
            r_x         <= '0;
            r_y         <= '0;
            r_cnt       <= '0;
            r_f         <= '0;
            r_pat       <= '0;
            r_tdata     <= '0;
            r_tuser     <= 1'b0;
            r_tlast     <= 1'b0;
            r_frame_cnt <= '0;
        end else if (w_load || (w_hs && !w_frame_end)) begin
            r_x     <= w_nx;
            r_y     <= w_ny;
            r_cnt   <= w_ncnt;
            r_f     <= w_nf;
            r_pat   <= w_npat;
            r_tdata <= w_beat;
            r_tuser <= (w_nx == '0) && (w_ny == '0);
            r_tlast <= (w_nx == X_LAST);
        end else if (w_frame_end) begin
            r_tuser     <= 1'b0;
            r_tlast     <= 1'b0;
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    always_ff @(posedge m_axis_video_aclk or posedge m_axis_video_arst) begin
        if (m_axis_video_arst) begin
            r_gap <= '0;
        end else if ((r_state == ST_GAP) && !w_gap_done) begin
            r_gap <= r_gap + GW'(1);
        end else begin
            r_gap <= '0;
        end
    end

    assign VIDEO_OUT_tdata  = r_tdata;
    assign VIDEO_OUT_tvalid = (r_state == ST_ACTIVE);
    assign VIDEO_OUT_tuser  = r_tuser;
    assign VIDEO_OUT_tlast  = r_tlast;
    assign frame_cnt        = r_frame_cnt;
    assign busy             = (r_state != ST_IDLE);
    assign state_dbg        = r_state;

endmodule
